// File: rtl/grant_burst_pkg.sv
// Shared types and helpers for the grant-driven burst controller.
package grant_burst_pkg;

  // Default geometry; the top module recomputes these from its own parameters.
  localparam int N_DEF      = 4;
  localparam int MAXLEN_DEF = 8;
  localparam int IW         = (N_DEF > 1) ? $clog2(N_DEF) : 1;
  localparam int LW         = $clog2(MAXLEN_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  // True when exactly one bit is set; narrower vectors are zero-extended by the caller.
  function automatic logic is_onehot(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/grant_burst_ctrl_onehot_enc.sv
// One-hot to binary encoder that also classifies the input as a clean one-hot
// grant or as a corrupt multi-bit grant.
module onehot_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid,
  output logic          err
);

  import grant_burst_pkg::*;

  int unsigned ones;

  // OR together the indices of set bits and count them; the index is only meaningful when exactly one bit is set.
  always_comb begin
    idx  = '0;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx  = idx | IW'(i);
        ones = ones + 1;
      end
    end
    valid = is_onehot(32'(vec));
    err   = (ones > 1);
  end

endmodule

// File: rtl/grant_burst_ctrl.sv
// Consumes a registered one-hot arbiter grant, latches the winner as owner and
// streams its burst onto a shared valid/ready channel, then signals completion.
module grant_burst_ctrl #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int MAXLEN = 8,
  parameter int IW     = (N > 1) ? $clog2(N) : 1,
  parameter int LW     = $clog2(MAXLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    gnt,
  input  logic [N*LW-1:0] req_len,
  input  logic [N*DW-1:0] req_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_id,
  output logic            out_last,
  output logic [N-1:0]    beat_ack,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic            gnt_err
);

  import grant_burst_pkg::*;

  localparam logic [LW-1:0] MAX_CNT = LW'(MAXLEN);

  state_t        state;
  logic [IW-1:0] owner;
  logic [LW-1:0] cnt;

  logic [IW-1:0] enc_idx;
  logic          enc_valid;
  logic          enc_err;
  logic [LW-1:0] lane_len;
  logic [LW-1:0] clamped_len;
  logic          beat;

  onehot_enc #(.N(N), .IW(IW)) u_enc (
    .vec   (gnt),
    .idx   (enc_idx),
    .valid (enc_valid),
    .err   (enc_err)
  );

  // Pick the granted requester's length lane and clamp it to the longest burst we support.
  always_comb begin
    lane_len    = req_len[enc_idx*LW +: LW];
    clamped_len = (lane_len > MAX_CNT) ? MAX_CNT : lane_len;
  end

  assign beat = (state == XFER) && out_ready;

  // Main FSM with owner and remaining-beat counter; a stale grant is soaked up by the GAP cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_valid) begin
            owner <= enc_idx;
            cnt   <= clamped_len;
            state <= (clamped_len != '0) ? XFER : DONE;
          end
        end
        XFER: begin
          if (beat && (cnt != '0)) begin
            cnt <= cnt - LW'(1);
            if (cnt == LW'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode is purely a function of state and owner, except the beat handshake and data lane mux.
  always_comb begin
    out_valid = (state == XFER);
    out_id    = owner;
    out_last  = (state == XFER) && (cnt == LW'(1));
    out_data  = req_data[owner*DW +: DW];
    beat_ack  = '0;
    done      = '0;
    if (beat) begin
      beat_ack[owner] = 1'b1;
    end
    if (state == DONE) begin
      done[owner] = 1'b1;
    end
    busy    = (state != IDLE);
    gnt_err = (state == IDLE) && enc_err;
  end

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Directed self-checking bench for grant_burst_ctrl.
module tb_grant_burst_ctrl;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int MAXLEN = 8;
  localparam int IW     = 2;
  localparam int LW     = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    gnt;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            out_last;
  logic [N-1:0]    beat_ack;
  logic [N-1:0]    done;
  logic            busy;
  logic            gnt_err;

  int tests;
  int fails;

  grant_burst_ctrl #(.N(N), .DW(DW), .MAXLEN(MAXLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .gnt       (gnt),
    .req_len   (req_len),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .beat_ack  (beat_ack),
    .done      (done),
    .busy      (busy),
    .gnt_err   (gnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int lane, input int len);
    req_len[lane*LW +: LW] = LW'(len);
  endtask

  task automatic set_data(input int lane, input int val);
    req_data[lane*DW +: DW] = DW'(val);
  endtask

  // Let the controller finish DONE/GAP and return to IDLE.
  task automatic drain();
    gnt = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; gnt = 4'b0100; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if ({out_valid, out_id, out_last, beat_ack, done, busy, gnt_err} !== '0) begin
        fails++;
        $display("[TB] FAIL reset_outputs cycle %0d: valid=%b id=%0d last=%b ack=%b done=%b busy=%b err=%b, all required 0",
                 c, out_valid, out_id, out_last, beat_ack, done, busy, gnt_err);
      end
    end
    gnt = '0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_burst();
    set_len(2, 3);
    set_data(2, 8'h55);
    out_ready = 1'b1;
    gnt = 4'b0100;
    tick();
    for (int b = 0; b < 3; b++) begin
      tests++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 || beat_ack !== 4'b0100 || out_last !== (b == 2) || out_data !== 8'h55) begin
        fails++;
        $display("[TB] FAIL basic_beat %0d: valid=%b id=%0d ack=%b last=%b data=%h, required 1/2/0100/%b/55",
                 b, out_valid, out_id, beat_ack, out_last, out_data, (b == 2));
      end
      tick();
    end
    tests++;
    if (done !== 4'b0100 || out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_done: done=%b valid=%b busy=%b, required 0100/0/1", done, out_valid, busy);
    end
    gnt = '0;
    tick();
    tests++;
    if (busy !== 1'b1 || done !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL basic_gap: busy=%b done=%b, required 1/0000", busy, done);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_stall();
    logic ready_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int d;
    int acks;
    d = 8'hA0;
    acks = 0;
    set_len(2, 3);
    set_data(2, d);
    gnt = 4'b0100;
    tick();
    for (int c = 0; c < 5; c++) begin
      out_ready = ready_pat[c];
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== DW'(d) || out_last !== (c == 4) || beat_ack !== (ready_pat[c] ? 4'b0100 : 4'b0000)) begin
        fails++;
        $display("[TB] FAIL stall_cycle %0d: valid=%b data=%h last=%b ack=%b, required 1/%h/%b/%b",
                 c, out_valid, out_data, out_last, beat_ack, DW'(d), (c == 4), (ready_pat[c] ? 4'b0100 : 4'b0000));
      end
      if (beat_ack[2]) acks++;
      tick();
      if (ready_pat[c]) begin
        d++;
        set_data(2, d);
      end
    end
    out_ready = 1'b1;
    tests++;
    if (acks != 3 || done !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL stall_done: acks=%0d done=%b, required 3/0100", acks, done);
    end
    drain();
  endtask

  task automatic test_lengths();
    int beats;
    int cyc;
    set_len(0, 0);
    gnt = 4'b0001;
    tick();
    tests++;
    if (out_valid !== 1'b0 || done !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL zero_len: valid=%b done=%b, required 0/0001", out_valid, done);
    end
    drain();
    set_len(0, 15);
    gnt = 4'b0001;
    beats = 0;
    cyc = 0;
    tick();
    while (done !== 4'b0001 && cyc < 20) begin
      if (beat_ack === 4'b0001) beats++;
      tick();
      cyc++;
    end
    tests++;
    if (cyc >= 20 || beats != 8) begin
      fails++;
      $display("[TB] FAIL clamp_len: beats=%0d timeout=%b, required 8 beats", beats, (cyc >= 20));
    end
    drain();
  endtask

  task automatic test_grant_errors();
    int cyc;
    gnt = 4'b0110;
    #1;
    tests++;
    if (gnt_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL gnt_err_pulse: gnt_err=%b, required 1", gnt_err);
    end
    tick();
    gnt = '0;
    #1;
    tests++;
    if (busy !== 1'b0 || gnt_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL gnt_err_idle: busy=%b gnt_err=%b, required 0/0", busy, gnt_err);
    end
    set_len(3, 4);
    gnt = 4'b1000;
    tick();
    gnt = 4'b0010;
    tick();
    tests++;
    if (out_id !== 2'd3 || out_valid !== 1'b1 || beat_ack !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL switch_ignored: id=%0d valid=%b ack=%b, required 3/1/1000", out_id, out_valid, beat_ack);
    end
    gnt = 4'b0110;
    #1;
    tests++;
    if (gnt_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL gnt_err_busy: gnt_err=%b, required 0", gnt_err);
    end
    cyc = 0;
    while (done === 4'b0000 && cyc < 10) begin
      tick();
      cyc++;
    end
    tests++;
    if (done !== 4'b1000 || cyc != 3) begin
      fails++;
      $display("[TB] FAIL switch_done: done=%b after %0d cycles, required 1000 after 3", done, cyc);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    int cyc;
    set_len(3, 4);
    gnt = 4'b1000;
    tick();
    tick();
    rst = 1'b0;
    gnt = '0;
    tick();
    tests++;
    if ({out_valid, out_id, out_last, beat_ack, done, busy, gnt_err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_abort: valid=%b id=%0d last=%b ack=%b done=%b busy=%b, all required 0",
               out_valid, out_id, out_last, beat_ack, done, busy);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (done !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_no_done: done=%b busy=%b, required 0000/0", done, busy);
    end
    set_len(3, 2);
    gnt = 4'b1000;
    beats = 0;
    cyc = 0;
    tick();
    while (done !== 4'b1000 && cyc < 10) begin
      if (beat_ack === 4'b1000 && out_id === 2'd3) beats++;
      tick();
      cyc++;
    end
    tests++;
    if (cyc >= 10 || beats != 2) begin
      fails++;
      $display("[TB] FAIL post_reset_burst: beats=%0d timeout=%b, required 2 beats", beats, (cyc >= 10));
    end
    drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    gnt = '0;
    req_len = '0;
    req_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic_burst();
    test_stall();
    test_lengths();
    test_grant_errors();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
